// File: rtl/ones_pkg.sv
// ones_pkg: shared types and widths for the frame popcount pipeline.
package ones_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W = 4;
    localparam int DEF_SUM_W = 16;
    localparam int DEF_LEN_W = 12;
    typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/count_ones.sv
// count_ones: combinational popcount of one byte.
module count_ones
    import ones_pkg::*;
(
    input  logic [BYTE_W-1:0] in,
    output logic [CNT_W-1:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < BYTE_W; i++) count += CNT_W'(in[i]);
    end
endmodule

// File: rtl/ones_frame_counter.sv
// ones_frame_counter: per-frame saturating ones/byte totals on a valid/ready result port.
module ones_frame_counter
    import ones_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_bytes,
    output logic              out_sat
);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] acc_sum, nxt_sum;
    logic [LEN_W-1:0] acc_len, nxt_len;
    logic [SUM_W:0] sum_wide;
    logic acc_sat, nxt_sat, len_full;

    count_ones u_count (.in(in_data), .count(cnt));

    // One extra bit catches overflow so the total clamps instead of wrapping.
    assign sum_wide = {1'b0, acc_sum} + (SUM_W+1)'(cnt);
    assign len_full = &acc_len;
    assign nxt_sum = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    assign nxt_len = len_full ? acc_len : acc_len + LEN_W'(1);
    assign nxt_sat = acc_sat | sum_wide[SUM_W] | len_full;
    assign in_ready = state == ACCUM;
    assign out_valid = state == HOLD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc_sum <= '0;
            acc_len <= '0;
            acc_sat <= 1'b0;
            out_sum <= '0;
            out_bytes <= '0;
            out_sat <= 1'b0;
        end else if (clr) begin
            state <= ACCUM;
            acc_sum <= '0;
            acc_len <= '0;
            acc_sat <= 1'b0;
        end else if (state == ACCUM) begin
            if (in_valid && in_last) begin
                out_sum <= nxt_sum;
                out_bytes <= nxt_len;
                out_sat <= nxt_sat;
                acc_sum <= '0;
                acc_len <= '0;
                acc_sat <= 1'b0;
                state <= HOLD;
            end else if (in_valid) begin
                acc_sum <= nxt_sum;
                acc_len <= nxt_len;
                acc_sat <= nxt_sat;
            end
        end else if (out_ready) begin
            state <= ACCUM;
        end
    end
endmodule
